// File: rtl/adc_arb_pkg.sv
// adc_arb_pkg: shared types and constants for the ADC arbiter
package adc_arb_pkg;
  typedef enum logic [1:0] {IDLE, WR, RD, RESP} state_t;
  localparam int ADC_CH_W = 3;
  localparam int ADC_DATA_W = 12;
  localparam logic [ADC_CH_W-1:0] ADC_CSR_ADDR = '0;
  localparam logic [31:0] ADC_RUN_CMD = 32'h1;
endpackage

// File: rtl/adc_arbiter_if.sv
// adc_arbiter_if: requester-side and ADC Avalon-MM signals of the arbiter
interface adc_arbiter_if #(parameter int NUM_REQ = 2);
  import adc_arb_pkg::*;
  logic [NUM_REQ-1:0] req;
  logic [ADC_CH_W*NUM_REQ-1:0] req_ch;
  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] rsp_valid;
  logic [ADC_DATA_W-1:0] rsp_data;
  logic rsp_err;
  logic adc_write;
  logic adc_read;
  logic [ADC_CH_W-1:0] adc_address;
  logic [31:0] adc_write_data;
  logic [31:0] adc_read_data;
  logic adc_wait_request;
  modport slave (
    input req, req_ch, adc_read_data, adc_wait_request,
    output pending, rsp_valid, rsp_data, rsp_err, adc_write, adc_read, adc_address, adc_write_data
  );
  modport master (
    output req, req_ch, adc_read_data, adc_wait_request,
    input pending, rsp_valid, rsp_data, rsp_err, adc_write, adc_read, adc_address, adc_write_data
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first pending bit at or above rr
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pending_i,
  input  logic [IW-1:0]      rr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IW-1:0]      idx_o,
  output logic               any_o
);
  // scan offsets downward so the smallest offset from rr is the last, winning assignment
  always_comb begin
    idx_o = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (pending_i[(int'(rr_i) + k) % NUM_REQ]) idx_o = IW'((int'(rr_i) + k) % NUM_REQ);
  end
  assign any_o = |pending_i;
  assign grant_o = any_o ? NUM_REQ'(1) << idx_o : '0;
endmodule

// File: rtl/adc_arbiter.sv
// adc_arbiter: round-robin sharing of one ADC Avalon-MM slave; ADC_ARB_TIMEOUT_EN adds a wait-request watchdog
module adc_arbiter
  import adc_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int NUM_CH = 6,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic clk,
  input logic reset,
  adc_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  state_t state_q, state_d;
  logic [NUM_REQ-1:0] pending_q, gnt_q, gnt_d, grant, clr;
  logic [ADC_CH_W-1:0] ch_q [NUM_REQ];
  logic [IW-1:0] rr_q, rr_d, idx_q, idx_d, gidx;
  logic [ADC_CH_W-1:0] cur_ch_q, cur_ch_d;
  logic [ADC_DATA_W-1:0] data_q, data_d;
  logic err_q, err_d, any, tmo, unused_rdata;
  assign unused_rdata = ^bus.adc_read_data[31:ADC_DATA_W];
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .pending_i(pending_q),
    .rr_i(rr_q),
    .grant_o(grant),
    .idx_o(gidx),
    .any_o(any)
  );
`ifdef ADC_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  assign tmo = bus.adc_wait_request && cnt_q == 16'(TIMEOUT_CYCLES - 1);
  assign cnt_d = (state_q inside {WR, RD}) && state_d == state_q ? cnt_q + 16'd1 : '0;
  // watchdog counts wait-request cycles since entering WR or RD
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign tmo = 1'b0;
`endif
  // next state, grant capture and response data
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    idx_d = idx_q;
    gnt_d = gnt_q;
    cur_ch_d = cur_ch_q;
    data_d = data_q;
    err_d = err_q;
    case (state_q)
      IDLE:
        if (any) begin
          idx_d = gidx;
          gnt_d = grant;
          cur_ch_d = ch_q[gidx];
          state_d = int'(ch_q[gidx]) >= NUM_CH ? RESP : WR;
          if (int'(ch_q[gidx]) >= NUM_CH) begin
            err_d = 1'b1;
            data_d = '0;
          end
        end
      WR:
        if (!bus.adc_wait_request) state_d = RD;
        else if (tmo) begin
          err_d = 1'b1;
          data_d = '0;
          state_d = RESP;
        end
      RD:
        if (!bus.adc_wait_request) begin
          data_d = bus.adc_read_data[ADC_DATA_W-1:0];
          err_d = 1'b0;
          state_d = RESP;
        end else if (tmo) begin
          err_d = 1'b1;
          data_d = '0;
          state_d = RESP;
        end
      RESP: begin
        rr_d = idx_q == IW'(NUM_REQ - 1) ? '0 : idx_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign clr = state_q == RESP ? gnt_q : '0;
  // state registers and per-requester pending slots; a new request beats the RESP clear
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      pending_q <= '0;
      rr_q <= '0;
      idx_q <= '0;
      gnt_q <= '0;
      cur_ch_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) ch_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pending_q <= (pending_q & ~clr) | bus.req;
      rr_q <= rr_d;
      idx_q <= idx_d;
      gnt_q <= gnt_d;
      cur_ch_q <= cur_ch_d;
      data_q <= data_d;
      err_q <= err_d;
      for (int i = 0; i < NUM_REQ; i++)
        if (bus.req[i]) ch_q[i] <= bus.req_ch[ADC_CH_W*i +: ADC_CH_W];
    end
  assign bus.pending = pending_q;
  assign bus.rsp_valid = clr;
  assign bus.rsp_data = data_q;
  assign bus.rsp_err = err_q;
  assign bus.adc_write = state_q == WR;
  assign bus.adc_read = state_q == RD;
  assign bus.adc_address = state_q == RD ? cur_ch_q : state_q == WR ? ADC_CSR_ADDR : '0;
  assign bus.adc_write_data = state_q == WR ? ADC_RUN_CMD : '0;
endmodule

// File: tb/tb_adc_arbiter.sv
// tb_adc_arbiter: directed cycle-accurate checks of the ADC arbiter
module tb_adc_arbiter;
`ifdef ADC_ARB_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 1024;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  adc_arbiter_if #(.NUM_REQ(2)) bus ();
  adc_arbiter #(.NUM_REQ(2), .NUM_CH(6), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic post(input logic [1:0] r, input logic [5:0] ch);
    bus.req = r;
    bus.req_ch = ch;
  endtask
  task automatic chk_zero(input string tag);
    chk(tag, {bus.pending, bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.adc_write, bus.adc_read, bus.adc_address}, 0);
    chk({tag, "_wd"}, bus.adc_write_data, 0);
  endtask
  task automatic do_reset;
    reset = 1'b1;
    #2;
    chk_zero("rst");
    tick;
    reset = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal;
  end
  initial begin
    post(2'b00, 6'o00);
    bus.adc_read_data = 32'h0;
    bus.adc_wait_request = 1'b0;
    do_reset;
    post(2'b01, 6'o02);
    bus.adc_read_data = 32'hFFFF_F5A3;
    tick;
    post(2'b00, 6'o00);
    chk("t1_pend", bus.pending, 2'b01);
    chk("t1_idle", {bus.adc_write, bus.adc_read}, 2'b00);
    tick;
    chk("t1_wr", {bus.adc_write, bus.adc_read, bus.adc_address}, 5'b10_000);
    chk("t1_wd", bus.adc_write_data, 32'h1);
    tick;
    chk("t1_rd", {bus.adc_write, bus.adc_read, bus.adc_address}, 5'b01_010);
    tick;
    chk("t1_vld", bus.rsp_valid, 2'b01);
    chk("t1_data", bus.rsp_data, 12'h5A3);
    chk("t1_err", bus.rsp_err, 1'b0);
    tick;
    chk("t1_hold", {bus.rsp_valid, bus.rsp_data}, 14'h05A3);
    chk("t1_clr", bus.pending, 2'b00);
    do_reset;
    bus.adc_read_data = 32'h0000_0123;
    post(2'b11, 6'o10);
    for (int c = 1; c <= 13; c++) begin
      tick;
      chk($sformatf("t2_vld%0d", c), bus.rsp_valid, c == 4 ? 2'b01 : c == 8 ? 2'b10 : c == 12 ? 2'b01 : 2'b00);
      if (c == 1) post(2'b00, 6'o00);
      if (c == 4) post(2'b11, 6'o10);
      if (c == 5) begin
        post(2'b00, 6'o00);
        chk("t2_pend", bus.pending, 2'b11);
      end
      if (c == 7) chk("t2_rd1", {bus.adc_read, bus.adc_address}, 4'b1_001);
      if (c == 8) chk("t2_data", bus.rsp_data, 12'h123);
    end
    post(2'b01, 6'o03);
    bus.adc_read_data = 32'h1234_5ABC;
    for (int c = 1; c <= 10; c++) begin
      logic w, r;
      tick;
      if (c == 1) post(2'b00, 6'o00);
      w = c >= 2 && c <= 5;
      r = c >= 6 && c <= 8;
      chk($sformatf("t3_cmd%0d", c), {bus.adc_write, bus.adc_read, bus.adc_address, bus.adc_write_data[0]},
          {w, r, r ? 3'd3 : 3'd0, w});
      chk($sformatf("t3_vld%0d", c), bus.rsp_valid, c == 9 ? 2'b01 : 2'b00);
      if (c == 9) chk("t3_data", {bus.rsp_err, bus.rsp_data}, 13'h0ABC);
      bus.adc_wait_request = (c >= 2 && c <= 4) || c == 6 || c == 7;
    end
    post(2'b10, 6'o70);
    for (int c = 1; c <= 4; c++) begin
      tick;
      if (c == 1) begin
        post(2'b00, 6'o00);
        chk("t4_pend", bus.pending, 2'b10);
      end
      chk($sformatf("t4_cmd%0d", c), {bus.adc_write, bus.adc_read}, 2'b00);
      chk($sformatf("t4_vld%0d", c), bus.rsp_valid, c == 2 ? 2'b10 : 2'b00);
      if (c == 2) chk("t4_err", {bus.rsp_err, bus.rsp_data}, 13'h1000);
    end
    post(2'b01, 6'o01);
    tick;
    post(2'b00, 6'o00);
    tick;
    tick;
    chk("t5_rd", {bus.adc_read, bus.adc_address}, 4'b1_001);
    reset = 1'b1;
    #1;
    chk_zero("t5_async");
    tick;
    tick;
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick;
      chk($sformatf("t5_quiet%0d", c), {bus.rsp_valid, bus.adc_write, bus.adc_read, bus.pending}, 0);
    end
    post(2'b01, 6'o05);
    bus.adc_read_data = 32'hABCD_E001;
    tick;
    post(2'b00, 6'o00);
    tick;
    tick;
    chk("t6_rd", {bus.adc_read, bus.adc_address}, 4'b1_101);
    tick;
    chk("t6_vld", {bus.rsp_valid, bus.rsp_err, bus.rsp_data}, 15'h2001);
    tick;
`ifdef ADC_ARB_TIMEOUT_EN
    post(2'b01, 6'o00);
    bus.adc_wait_request = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      tick;
      if (c == 1) post(2'b00, 6'o00);
      chk($sformatf("t7_wr%0d", c), {bus.adc_write, bus.adc_read}, {c >= 2 && c <= 9, 1'b0});
      chk($sformatf("t7_vld%0d", c), bus.rsp_valid, c == 10 ? 2'b01 : 2'b00);
      if (c == 10) chk("t7_err", {bus.rsp_err, bus.rsp_data}, 13'h1000);
    end
    bus.adc_wait_request = 1'b0;
    bus.adc_read_data = 32'h0000_0777;
    post(2'b01, 6'o02);
    tick;
    post(2'b00, 6'o00);
    tick;
    tick;
    tick;
    chk("t7_next", {bus.rsp_valid, bus.rsp_err, bus.rsp_data}, 15'h2777);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
